// File: rtl/tcdm_initiator_port.sv
`default_nettype none
// tcdm_initiator_port: core valid/ready -> TCDM req/gnt adapter with credit-bounded response FIFO.
// Rev 1.0
module tcdm_initiator_port #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter bit          WriteRespOn    = 1'b1,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_req_valid_i,
  output logic                 core_req_ready_o,
  input  logic [AddrWidth-1:0] core_add_i,
  input  logic                 core_wen_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic [BeWidth-1:0]   core_be_i,
  output logic                 core_resp_valid_o,
  input  logic                 core_resp_ready_i,
  output logic [DataWidth-1:0] core_resp_rdata_o,
  output logic                 req_o,
  output logic [AddrWidth-1:0] add_o,
  output logic                 wen_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  input  logic                 gnt_i,
  input  logic                 vld_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;
  localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);

  logic [CntWidth-1:0]  credits;
  logic [CntWidth-1:0]  pending;
  logic [CntWidth-1:0]  fifo_cnt;
  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [DataWidth-1:0] fifo_mem [MaxOutstanding];

  logic in_needs_resp;
  logic held_needs_resp;
  logic accept;
  logic granted;
  logic pop;
  logic push;
  logic fifo_full;
  logic stale;
  logic drop_full;

  assign in_needs_resp   = ~core_wen_i | WriteRespOn;
  assign held_needs_resp = ~wen_o | WriteRespOn;

  // Register can reload in the grant cycle, so ready looks through gnt_i.
  assign core_req_ready_o = (~req_o | gnt_i) & ((credits < MaxCnt) | ~in_needs_resp);
  assign accept           = core_req_valid_i & core_req_ready_o;
  assign granted          = req_o & gnt_i;

  assign core_resp_valid_o = (fifo_cnt != '0);
  assign core_resp_rdata_o = fifo_mem[rd_ptr];
  assign pop               = core_resp_valid_o & core_resp_ready_i;
  assign fifo_full         = (fifo_cnt == MaxCnt);

  // A response with nothing granted-but-unanswered can only be stale.
  assign stale     = vld_i & (pending == '0);
  assign push      = vld_i & ~stale & (~fifo_full | pop);
  assign drop_full = vld_i & ~stale & fifo_full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_o   <= 1'b0;
      add_o   <= '0;
      wen_o   <= 1'b0;
      wdata_o <= '0;
      be_o    <= '0;
    end else if (accept) begin
      req_o   <= 1'b1;
      add_o   <= core_add_i;
      wen_o   <= core_wen_i;
      wdata_o <= core_wdata_i;
      be_o    <= core_be_i;
    end else if (granted) begin
      req_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits <= '0;
    end else begin
      case ({accept & in_needs_resp, pop})
        2'b10:   credits <= credits + CntOne;
        2'b01:   credits <= credits - CntOne;
        default: credits <= credits;
      endcase
    end
  end

  // Granted-but-unanswered count; dropped-on-full responses still retire their slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= '0;
    end else begin
      case ({granted & held_needs_resp, vld_i & ~stale})
        2'b10:   pending <= pending + CntOne;
        2'b01:   pending <= pending - CntOne;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CntOne;
        2'b01:   fifo_cnt <= fifo_cnt - CntOne;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (stale | drop_full) begin
      err_o <= 1'b1;
    end
  end

endmodule
`default_nettype wire
